// File: rtl/apb_controller.sv
// rtl/apb_controller.sv - AHB-to-APB bridge master sequencing APB SETUP/ENABLE phases
//
// Samples AHB address/control, decodes one of four 64 MB APB windows at
// 0x8000_0000, and drives one APB transfer per accepted AHB transfer.
// Ports:
//   clk, Hresetn                 clock, synchronous active-low reset
//   Htrans, Hwrite, Haddr,
//   Hwdata, Hreadyin             AHB request side
//   Hreadyout, Hrdata, Hresp     AHB response side
//   Pselx, Penable, Pwrite,
//   Paddr, Pwdata, Prdata        APB master side
module apb_controller (
  input  logic        clk,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        Hreadyin,
  output logic        Hreadyout,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic [3:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_READ, S_RENABLE, S_WRITE, S_WENABLE
  } state_t;

  state_t      state, state_next;
  logic        valid;
  logic        can_sample;
  logic        sample;
  logic [3:0]  sel_dec;

  // Only NONSEQ/SEQ into the 0x8xxx_xxxx region start an APB transfer.
  assign valid      = Hreadyin && (Htrans inside {2'b10, 2'b11}) && (Haddr[31:28] == 4'h8);
  assign can_sample = (state == S_IDLE) || (state == S_RENABLE) || (state == S_WENABLE);
  assign sample     = valid && can_sample;
  assign sel_dec    = 4'b0001 << Haddr[27:26];
  assign Hresp      = 2'b00;

  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      state  <= S_IDLE;
      Pselx  <= 4'b0000;
      Pwrite <= 1'b0;
      Paddr  <= 32'h0;
      Pwdata <= 32'h0;
    end else begin
      state <= state_next;
      if (sample) begin
        Pselx  <= sel_dec;
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
      end else if (can_sample) begin
        // Nothing new after an ENABLE cycle: release the slave select.
        Pselx <= 4'b0000;
      end
      // The AHB data phase of a write coincides with the WWAIT cycle.
      if (state == S_WWAIT) begin
        Pwdata <= Hwdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    Hreadyout  = 1'b1;
    Penable    = 1'b0;
    Hrdata     = 32'h0;
    case (state)
      S_IDLE: begin
        if (sample) state_next = Hwrite ? S_WWAIT : S_READ;
      end
      S_WWAIT: begin
        Hreadyout  = 1'b0;
        state_next = S_WRITE;
      end
      S_READ: begin
        Hreadyout  = 1'b0;
        state_next = S_RENABLE;
      end
      S_RENABLE: begin
        Penable    = 1'b1;
        Hrdata     = Prdata;
        state_next = sample ? (Hwrite ? S_WWAIT : S_READ) : S_IDLE;
      end
      S_WRITE: begin
        Hreadyout  = 1'b0;
        state_next = S_WENABLE;
      end
      S_WENABLE: begin
        Penable    = 1'b1;
        state_next = sample ? (Hwrite ? S_WWAIT : S_READ) : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_controller.sv
// tb/tb_apb_controller.sv - self-checking bench for apb_controller
module tb_apb_controller;

  logic        clk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  int errors = 0;
  int checks = 0;
  bit run_check = 1'b0;

  always #5 clk = ~clk;

  assign Hreadyin = Hreadyout;

  apb_controller dut (
    .clk(clk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout),
    .Hrdata(Hrdata), .Hresp(Hresp), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted transfer becomes a list of future APB cycles.
  // kind 0 = write wait, 1 = setup, 2 = enable.
  typedef struct {
    int       kind;
    logic [3:0] sel;
    logic     wr;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite;
  logic [3:0]  m_sel;
  bit          m_rdy, m_acc;

  always @(posedge clk) begin
    if (!Hresetn) begin
      q.delete();
      m_paddr  = 32'h0;
      m_pwdata = 32'h0;
      m_pwrite = 1'b0;
    end else begin
      m_rdy = (q.size() == 0) || (q[0].kind == 2);
      m_acc = m_rdy && (Htrans >= 2'd2) && (Haddr >= 32'h8000_0000) && (Haddr <= 32'h8FFF_FFFF);
      if (q.size() != 0) begin
        if (q[0].kind == 0) m_pwdata = Hwdata;
        void'(q.pop_front());
      end
      if (m_acc) begin
        m_sel    = 4'b0001 << ((Haddr - 32'h8000_0000) / 32'h0400_0000);
        m_paddr  = Haddr;
        m_pwrite = Hwrite;
        if (Hwrite) q.push_back(cyc_t'{kind: 0, sel: m_sel, wr: 1'b1});
        q.push_back(cyc_t'{kind: 1, sel: m_sel, wr: Hwrite});
        q.push_back(cyc_t'{kind: 2, sel: m_sel, wr: Hwrite});
      end
    end
  end

  logic [3:0]  e_sel;
  logic        e_pen, e_rdy;
  logic [31:0] e_hrdata;

  always @(negedge clk) begin
    if (run_check) begin
      if (q.size() == 0) begin
        e_sel = 4'b0000; e_pen = 1'b0; e_rdy = 1'b1; e_hrdata = 32'h0;
      end else begin
        e_sel    = q[0].sel;
        e_pen    = (q[0].kind == 2);
        e_rdy    = (q[0].kind == 2);
        e_hrdata = (q[0].kind == 2 && !q[0].wr) ? Prdata : 32'h0;
      end
      check("m_pselx",     32'(Pselx),     32'(e_sel));
      check("m_penable",   32'(Penable),   32'(e_pen));
      check("m_hreadyout", 32'(Hreadyout), 32'(e_rdy));
      check("m_hrdata",    Hrdata,         e_hrdata);
      check("m_hresp",     32'(Hresp),     32'h0);
      check("m_paddr",     Paddr,          m_paddr);
      check("m_pwrite",    32'(Pwrite),    32'(m_pwrite));
      check("m_pwdata",    Pwdata,         m_pwdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an address phase, wait until it is accepted, then drive its data phase.
  task automatic xfer(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    Htrans = t; Hwrite = w; Haddr = a;
    while (!Hreadyout && k < 8) begin
      step();
      k++;
    end
    check("ready_wait", 32'(k < 8), 32'h1);
    step();
    Hwdata = d;
    Prdata = d ^ 32'hFFFF_0000;
  endtask

  typedef struct {
    logic [1:0]  t;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Hresetn = 1'b0; Htrans = 2'd0; Hwrite = 1'b0; Haddr = 32'h0;
    Hwdata = 32'h0; Prdata = 32'h0;
    repeat (3) step();
    check("rst_pselx",   32'(Pselx),     32'h0);
    check("rst_penable", 32'(Penable),   32'h0);
    check("rst_ready",   32'(Hreadyout), 32'h1);
    check("rst_paddr",   Paddr,          32'h0);
    check("rst_pwdata",  Pwdata,         32'h0);
    Hresetn = 1'b1;
    run_check = 1'b1;

    // Ignored transfers
    Htrans = 2'd0; Hwrite = 1'b1; Haddr = 32'h8000_0000; step();
    Htrans = 2'd1; step();
    Htrans = 2'd2; Haddr = 32'h9000_0000; step();
    check("ign_pselx", 32'(Pselx), 32'h0);
    Haddr = 32'h7FFF_FFFC; step();
    check("ign_ready", 32'(Hreadyout), 32'h1);
    check("ign_pen",   32'(Penable),   32'h0);
    check("ign_hresp", 32'(Hresp),     32'h0);
    Htrans = 2'd0;

    // Single write
    xfer(2'd2, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    Htrans = 2'd0;
    check("w_wwait_ready", 32'(Hreadyout), 32'h0);
    step();
    check("w_setup_sel",   32'(Pselx),     32'h1);
    check("w_setup_paddr", Paddr,          32'h8000_0010);
    check("w_setup_pwd",   Pwdata,         32'hDEAD_BEEF);
    check("w_setup_pen",   32'(Penable),   32'h0);
    check("w_setup_ready", 32'(Hreadyout), 32'h0);
    step();
    check("w_en_pen",   32'(Penable),   32'h1);
    check("w_en_ready", 32'(Hreadyout), 32'h1);
    step();
    check("w_idle_sel", 32'(Pselx), 32'h0);

    // Single read
    xfer(2'd2, 1'b0, 32'h8C00_0004, 32'h0);
    Htrans = 2'd0;
    Prdata = 32'h1234_5678;
    check("r_setup_sel",   32'(Pselx),     32'h8);
    check("r_setup_pen",   32'(Penable),   32'h0);
    check("r_setup_ready", 32'(Hreadyout), 32'h0);
    step();
    check("r_en_pen",    32'(Penable),   32'h1);
    check("r_en_hrdata", Hrdata,         32'h1234_5678);
    check("r_en_ready",  32'(Hreadyout), 32'h1);
    step();
    check("r_idle_hrdata", Hrdata, 32'h0);

    // Back-to-back read then write
    xfer(2'd2, 1'b0, 32'h8400_0000, 32'h0);
    Prdata = 32'hCAFE_0001;
    Htrans = 2'd3; Hwrite = 1'b1; Haddr = 32'h8800_0000;
    check("b2b_setup_sel", 32'(Pselx), 32'h2);
    step();
    check("b2b_en_sel", 32'(Pselx),   32'h2);
    check("b2b_en_pen", 32'(Penable), 32'h1);
    step();
    Htrans = 2'd0; Hwdata = 32'hA5A5_0F0F;
    check("b2b_wwait_sel",   32'(Pselx),     32'h4);
    check("b2b_wwait_pen",   32'(Penable),   32'h0);
    check("b2b_wwait_ready", 32'(Hreadyout), 32'h0);
    step();
    check("b2b_setup_pwd", Pwdata, 32'hA5A5_0F0F);
    repeat (2) step();

    // Pipelined mix, checked by the model
    vecs[0] = '{2'd3, 1'b1, 32'h8000_0100, 32'h1111_1111};
    vecs[1] = '{2'd3, 1'b1, 32'h8400_0200, 32'h2222_2222};
    vecs[2] = '{2'd2, 1'b0, 32'h8800_0300, 32'h3333_3333};
    vecs[3] = '{2'd3, 1'b0, 32'h8C00_0400, 32'h4444_4444};
    vecs[4] = '{2'd2, 1'b1, 32'h8FFF_FFFC, 32'h5555_5555};
    vecs[5] = '{2'd0, 1'b0, 32'h8000_0000, 32'h6666_6666};
    vecs[6] = '{2'd2, 1'b0, 32'h8000_0000, 32'h7777_7777};
    vecs[7] = '{2'd2, 1'b1, 32'h9000_0000, 32'h8888_8888};
    for (int i = 0; i < 8; i++) xfer(vecs[i].t, vecs[i].w, vecs[i].a, vecs[i].d);
    Htrans = 2'd0;
    repeat (4) step();

    // Reset in the middle of a write
    xfer(2'd2, 1'b1, 32'h8400_0008, 32'h55AA_55AA);
    Htrans = 2'd0;
    step();
    check("rw_in_setup", 32'(Pselx), 32'h2);
    Hresetn = 1'b0;
    step();
    check("rw_pselx", 32'(Pselx),     32'h0);
    check("rw_pen",   32'(Penable),   32'h0);
    check("rw_ready", 32'(Hreadyout), 32'h1);
    Hresetn = 1'b1;
    step();
    check("rw_no_enable", 32'(Penable), 32'h0);
    repeat (2) step();

    run_check = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
